// File: rtl/stripe_arbiter.sv
// Packet-level round-robin arbiter sharing a two-lane striping datapath between two sources.
// A granted source owns both lanes for a whole packet; its words alternate lane_0 / lane_1.
module stripe_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int MAX_PKT_WORDS = 16
) (
  input  logic                  clk_2f,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in0,
  input  logic                  valid_in0,
  input  logic                  last_in0,
  output logic                  ready_out0,
  input  logic [DATA_WIDTH-1:0] data_in1,
  input  logic                  valid_in1,
  input  logic                  last_in1,
  output logic                  ready_out1,
  input  logic                  lane_ready,
  output logic [DATA_WIDTH-1:0] lane_0,
  output logic [DATA_WIDTH-1:0] lane_1,
  output logic                  valid_0,
  output logic                  valid_1,
  output logic [1:0]            grant,
  output logic                  trunc_err
);

  localparam int CW = $clog2(MAX_PKT_WORDS);
  localparam logic [CW-1:0] LAST_IDX = CW'(MAX_PKT_WORDS - 1);

  typedef enum logic [1:0] {IDLE, SEND0, SEND1} state_t;

  state_t                  state;
  logic                    sel;
  logic [CW-1:0]           word_cnt;
  logic                    rr_last;

  logic                    own_valid;
  logic                    own_last;
  logic [DATA_WIDTH-1:0]   own_data;
  logic                    xfer;
  logic                    pkt_end;

  assign ready_out0 = (state == SEND0) & lane_ready;
  assign ready_out1 = (state == SEND1) & lane_ready;

  // Mux the current owner's word; the idle state selects nothing so no transfer can occur.
  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_data  = '0;
    case (state)
      SEND0: begin
        own_valid = valid_in0;
        own_last  = last_in0;
        own_data  = data_in0;
      end
      SEND1: begin
        own_valid = valid_in1;
        own_last  = last_in1;
        own_data  = data_in1;
      end
      default: ;
    endcase
  end

  assign xfer    = own_valid & lane_ready;
  assign pkt_end = own_last | (word_cnt == LAST_IDX);

  always_ff @(posedge clk_2f or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      sel       <= 1'b0;
      word_cnt  <= '0;
      rr_last   <= 1'b1;
      lane_0    <= '0;
      lane_1    <= '0;
      valid_0   <= 1'b0;
      valid_1   <= 1'b0;
      grant     <= 2'b00;
      trunc_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          valid_0   <= 1'b0;
          valid_1   <= 1'b0;
          trunc_err <= 1'b0;
          // rr_last names the previous winner; on contention the other source wins.
          if (valid_in0 && (!valid_in1 || rr_last)) begin
            state <= SEND0;
            grant <= 2'b01;
          end else if (valid_in1) begin
            state <= SEND1;
            grant <= 2'b10;
          end
        end
        default: begin
          if (xfer) begin
            if (sel) begin
              lane_1 <= own_data;
            end else begin
              lane_0 <= own_data;
            end
            valid_0   <= ~sel;
            valid_1   <= sel;
            sel       <= ~sel;
            word_cnt  <= word_cnt + 1'b1;
            trunc_err <= pkt_end & ~own_last;
            if (pkt_end) begin
              state    <= IDLE;
              grant    <= 2'b00;
              rr_last  <= (state == SEND1);
              sel      <= 1'b0;
              word_cnt <= '0;
            end
          end else begin
            valid_0   <= 1'b0;
            valid_1   <= 1'b0;
            trunc_err <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule
